// File: rtl/mcopy_pkg.sv
// mcopy_pkg: state encoding and bus widths for mem_copy_engine.
// Shared by the engine RTL and anything that decodes its bus phases.
package mcopy_pkg;

    localparam int DATA_W = 64;
    localparam int TAG_W  = 8;

    // Upper bits of o_ad while an address phase is on the bus.
    localparam logic [DATA_W-1:0] AD_PAD = '0;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        RD_WAIT,
        WR_ADDR,
        WR_DATA,
        FINISH
    } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus-master block copy of tagged 64-bit words.
// MEMCOPY_FILL_EN adds a pattern-fill mode (write-only sequence).
module mem_copy_engine
    import mcopy_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              cmd_wforce,
    input  logic              cmd_fill,
    input  logic [DATA_W-1:0] cmd_pattern,
    input  logic [TAG_W-1:0]  cmd_ptag,
    input  logic              cmd_abort,
    input  logic [DATA_W-1:0] i_data,
    input  logic [TAG_W-1:0]  i_tag,
    output logic [DATA_W-1:0] o_ad,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_astb,
    output logic              o_atomic,
    output logic              o_rd,
    output logic              o_wr,
    output logic              o_wforce,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  words_done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_words;
    logic [CNT_W-1:0]  w_words_nxt;
    logic              r_wforce;
    logic              r_abort;
    logic [DATA_W-1:0] r_data;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] w_wdata;
    logic [TAG_W-1:0]  w_wtag;
    logic              w_accept;
    logic              w_fill_cmd;
    logic              w_fill;
    logic              w_last;
    logic              w_abort_req;
    logic              w_in_cmd;

    assign w_accept    = (r_state == IDLE) && cmd_valid;
    assign w_in_cmd    = (r_state != IDLE) && (r_state != FINISH);
    assign w_words_nxt = r_words + CNT_W'(1);
    assign w_last      = (w_words_nxt == r_count);
    assign w_abort_req = r_abort || cmd_abort;

    assign words_done = r_words;
    assign aborted    = r_abort;
    assign o_atomic   = 1'b0;

`ifdef MEMCOPY_FILL_EN
    logic              r_fill;
    logic [DATA_W-1:0] r_pattern;
    logic [TAG_W-1:0]  r_ptag;

    assign w_fill_cmd = cmd_fill;
    assign w_fill     = r_fill;
    assign w_wdata    = r_fill ? r_pattern : r_data;
    assign w_wtag     = r_fill ? r_ptag : r_tag;

    // Fill-mode command fields, captured at accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill    <= 1'b0;
            r_pattern <= '0;
            r_ptag    <= '0;
        end else if (w_accept) begin
            r_fill    <= cmd_fill;
            r_pattern <= cmd_pattern;
            r_ptag    <= cmd_ptag;
        end
    end
`else
    logic w_unused_fill;

    assign w_fill_cmd    = 1'b0;
    assign w_fill        = 1'b0;
    assign w_wdata       = r_data;
    assign w_wtag        = r_tag;
    assign w_unused_fill = ^{cmd_fill, cmd_pattern, cmd_ptag};
`endif

    // State register; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bus outputs, decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        o_ad        = '0;
        o_tag       = '0;
        o_astb      = 1'b0;
        o_rd        = 1'b0;
        o_wr        = 1'b0;
        o_wforce    = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_count == '0) begin
                        w_state_nxt = FINISH;
                    end else if (w_fill_cmd) begin
                        w_state_nxt = WR_ADDR;
                    end else begin
                        w_state_nxt = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                o_astb      = 1'b1;
                o_ad        = AD_PAD | DATA_W'(r_src);
                w_state_nxt = RD_DATA;
            end
            RD_DATA: begin
                o_rd        = 1'b1;
                w_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                w_state_nxt = WR_ADDR;
            end
            WR_ADDR: begin
                o_astb      = 1'b1;
                o_ad        = AD_PAD | DATA_W'(r_dst);
                w_state_nxt = WR_DATA;
            end
            WR_DATA: begin
                o_wr     = 1'b1;
                o_ad     = w_wdata;
                o_tag    = w_wtag;
                o_wforce = r_wforce;
                if (w_last || w_abort_req) begin
                    w_state_nxt = FINISH;
                end else if (w_fill) begin
                    w_state_nxt = WR_ADDR;
                end else begin
                    w_state_nxt = RD_ADDR;
                end
            end
            FINISH: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Address/count datapath, read-data latch and sticky abort flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_count  <= '0;
            r_words  <= '0;
            r_wforce <= 1'b0;
            r_abort  <= 1'b0;
            r_data   <= '0;
            r_tag    <= '0;
        end else if (w_accept) begin
            r_src    <= cmd_src;
            r_dst    <= cmd_dst;
            r_count  <= cmd_count;
            r_words  <= '0;
            r_wforce <= cmd_wforce;
            r_abort  <= 1'b0;
        end else begin
            if (w_in_cmd && cmd_abort) begin
                r_abort <= 1'b1;
            end
            if (r_state == RD_WAIT) begin
                r_data <= i_data;
                r_tag  <= i_tag;
            end
            if (r_state == WR_DATA) begin
                r_src   <= r_src + ADDR_W'(1);
                r_dst   <= r_dst + ADDR_W'(1);
                r_words <= w_words_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: bus-level model plus per-cycle output compare.
// Exercises copy, zero count, wrap, abort, overlap, fill and reset.
module tb_mem_copy_engine;

    typedef struct packed {
        logic        rdy;
        logic        bsy;
        logic        astb;
        logic        rd;
        logic        wr;
        logic        wf;
        logic        at;
        logic        dn;
        logic [63:0] ad;
        logic [7:0]  tag;
        logic [19:0] wd;
        logic        chkab;
        logic        ab;
    } exp_t;

`ifdef MEMCOPY_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] cmd_src;
    logic [19:0] cmd_dst;
    logic [19:0] cmd_count;
    logic        cmd_wforce;
    logic        cmd_fill;
    logic [63:0] cmd_pattern;
    logic [7:0]  cmd_ptag;
    logic        cmd_abort;
    logic [63:0] i_data = '0;
    logic [7:0]  i_tag = '0;
    logic [63:0] o_ad;
    logic [7:0]  o_tag;
    logic        o_astb;
    logic        o_atomic;
    logic        o_rd;
    logic        o_wr;
    logic        o_wforce;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [19:0] words_done;

    mem_copy_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_count  (cmd_count),
        .cmd_wforce (cmd_wforce),
        .cmd_fill   (cmd_fill),
        .cmd_pattern(cmd_pattern),
        .cmd_ptag   (cmd_ptag),
        .cmd_abort  (cmd_abort),
        .i_data     (i_data),
        .i_tag      (i_tag),
        .o_ad       (o_ad),
        .o_tag      (o_tag),
        .o_astb     (o_astb),
        .o_atomic   (o_atomic),
        .o_rd       (o_rd),
        .o_wr       (o_wr),
        .o_wforce   (o_wforce),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          in_reset = 1'b1;
    exp_t        exp_q[$];
    logic [19:0] last_wd = '0;
    logic        last_ab = 1'b0;

    logic [63:0] mem_d[int];
    logic [7:0]  mem_t[int];
    logic [63:0] ref_d[int];
    logic [7:0]  ref_t[int];
    logic [19:0] rd_log[$];
    int          n_astb = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [19:0] alat = '0;
    logic [19:0] ra = '0;
    bit          rd_pend = 1'b0;

    function automatic logic [63:0] dflt_d(input logic [19:0] a);
        return 64'hC0DE_0000_0000_0000 | {44'b0, a};
    endfunction

    function automatic logic [7:0] dflt_t(input logic [19:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [63:0] mget_d(input logic [19:0] a);
        if (mem_d.exists(int'(a))) return mem_d[int'(a)];
        return dflt_d(a);
    endfunction

    function automatic logic [7:0] mget_t(input logic [19:0] a);
        if (mem_t.exists(int'(a))) return mem_t[int'(a)];
        return dflt_t(a);
    endfunction

    function automatic logic [63:0] rget_d(input logic [19:0] a);
        if (ref_d.exists(int'(a))) return ref_d[int'(a)];
        return dflt_d(a);
    endfunction

    function automatic logic [7:0] rget_t(input logic [19:0] a);
        if (ref_t.exists(int'(a))) return ref_t[int'(a)];
        return dflt_t(a);
    endfunction

    function automatic exp_t idle_e(input logic [19:0] wd, input logic ab);
        exp_t e;
        e       = '0;
        e.rdy   = 1'b1;
        e.wd    = wd;
        e.chkab = 1'b1;
        e.ab    = ab;
        return e;
    endfunction

    function automatic exp_t busy_e(input int wd);
        exp_t e;
        e     = '0;
        e.bsy = 1'b1;
        e.wd  = 20'(wd);
        return e;
    endfunction

    task automatic poke(input logic [19:0] a, input logic [63:0] d,
                        input logic [7:0] t);
        mem_d[int'(a)] = d;
        mem_t[int'(a)] = t;
        ref_d[int'(a)] = d;
        ref_t[int'(a)] = t;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected bus trace of one command, one entry per cycle from accept.
    task automatic build(input logic [19:0] s, input logic [19:0] d,
                         input logic wf, input logic fl,
                         input logic [63:0] pat, input logic [7:0] pt,
                         input int nw, input logic ab);
        exp_t        e;
        logic [19:0] sa;
        logic [19:0] da;
        logic [63:0] v;
        logic [7:0]  t;
        exp_q.push_back(idle_e(last_wd, last_ab));
        for (int k = 0; k < nw; k++) begin
            sa = s + 20'(k);
            da = d + 20'(k);
            if (fl) begin
                v = pat;
                t = pt;
            end else begin
                e = busy_e(k); e.astb = 1'b1; e.ad = {44'b0, sa};
                exp_q.push_back(e);
                e = busy_e(k); e.rd = 1'b1;
                exp_q.push_back(e);
                exp_q.push_back(busy_e(k));
                v = rget_d(sa);
                t = rget_t(sa);
            end
            e = busy_e(k); e.astb = 1'b1; e.ad = {44'b0, da};
            exp_q.push_back(e);
            e = busy_e(k); e.wr = 1'b1; e.ad = v; e.tag = t; e.wf = wf;
            exp_q.push_back(e);
            ref_d[int'(da)] = v;
            ref_t[int'(da)] = t;
        end
        e = busy_e(nw); e.dn = 1'b1; e.chkab = 1'b1; e.ab = ab;
        exp_q.push_back(e);
        last_wd = 20'(nw);
        last_ab = ab;
    endtask

    // Issue a command; aw>0 pulses cmd_abort in word aw's RD_DATA cycle.
    task automatic run(input logic [19:0] s, input logic [19:0] d,
                       input int n, input logic wf, input logic fl,
                       input logic [63:0] pat, input logic [7:0] pt,
                       input int aw, output int lat);
        int   nw;
        logic ab;
        nw = (aw > 0 && aw < n) ? aw : n;
        ab = (aw > 0 && aw <= n);
        @(posedge clk);
        #1;
        cmd_src     = s;
        cmd_dst     = d;
        cmd_count   = 20'(n);
        cmd_wforce  = wf;
        cmd_fill    = fl;
        cmd_pattern = pat;
        cmd_ptag    = pt;
        cmd_valid   = 1'b1;
        build(s, d, wf, fl && FILL_ON, pat, pt, nw, ab);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 600; c++) begin
            cmd_abort = (aw > 0) && (c == 5 * (aw - 1) + 2);
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        cmd_abort = 1'b0;
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL done_timeout actual=none required=done");
        end
    endtask

    // Memory side of the bus: registered read, one cycle after o_rd.
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_pend = 1'b0;
            i_data  = 64'hBADD_BADD_BADD_BADD;
            i_tag   = 8'hEE;
        end else begin
            if (rd_pend) begin
                i_data = mget_d(ra);
                i_tag  = mget_t(ra);
            end else begin
                i_data = 64'hBADD_BADD_BADD_BADD;
                i_tag  = 8'hEE;
            end
            rd_pend = 1'b0;
            if (o_astb) begin
                alat = o_ad[19:0];
                n_astb++;
            end
            if (o_rd) begin
                rd_pend = 1'b1;
                ra      = alat;
                rd_log.push_back(alat);
                n_rd++;
            end
            if (o_wr) begin
                mem_d[int'(alat)] = o_ad;
                mem_t[int'(alat)] = o_tag;
                n_wr++;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model trace.
    always @(negedge clk) begin : cmp
        exp_t e;
        exp_t a;
        if (!in_reset) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = idle_e(last_wd, last_ab);
            a.rdy   = cmd_ready;
            a.bsy   = busy;
            a.astb  = o_astb;
            a.rd    = o_rd;
            a.wr    = o_wr;
            a.wf    = o_wforce;
            a.at    = o_atomic;
            a.dn    = done;
            a.ad    = o_ad;
            a.tag   = o_tag;
            a.wd    = words_done;
            a.chkab = e.chkab;
            a.ab    = e.chkab ? aborted : e.ab;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0t actual=%h required=%h",
                         $time, a, e);
            end
        end
    end

    initial begin
        int lat;
        int s_astb;
        int s_rd;
        int s_wr;
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_src     = '0;
        cmd_dst     = '0;
        cmd_count   = '0;
        cmd_wforce  = 1'b0;
        cmd_fill    = 1'b0;
        cmd_pattern = '0;
        cmd_ptag    = '0;
        cmd_abort   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_strobes", {o_astb, o_rd, o_wr, o_wforce, o_atomic}, 0);
        check("rst_ad", o_ad, 0);
        check("rst_done_ab", {done, aborted}, 0);
        check("rst_words", words_done, 0);
        reset_n  = 1'b1;
        in_reset = 1'b0;

        for (int k = 0; k < 4; k++)
            poke(20'h100 + 20'(k), 64'h1234_5678_0000_0100 + 64'(k), 8'h35);

        run(20'h100, 20'h200, 4, 1'b0, 1'b0, '0, '0, 0, lat);
        check("copy_lat", lat, 21);
        check("copy_words", words_done, 4);
        check("copy_ab", aborted, 0);
        for (int k = 0; k < 4; k++) begin
            check("copy_data", mget_d(20'h200 + 20'(k)),
                  64'h1234_5678_0000_0100 + 64'(k));
            check("copy_tag", mget_t(20'h200 + 20'(k)), 8'h35);
        end

        s_astb = n_astb;
        s_rd   = n_rd;
        s_wr   = n_wr;
        run(20'h100, 20'h280, 0, 1'b0, 1'b0, '0, '0, 0, lat);
        check("zero_lat", lat, 1);
        check("zero_bus", (n_astb - s_astb) + (n_rd - s_rd) + (n_wr - s_wr), 0);
        check("zero_words", words_done, 0);

        rd_log.delete();
        run(20'hFFFFF, 20'h300, 2, 1'b1, 1'b0, '0, '0, 0, lat);
        check("wrap_nrd", rd_log.size(), 2);
        check("wrap_rd0", rd_log[0], 20'hFFFFF);
        check("wrap_rd1", rd_log[1], 20'h00000);
        check("wrap_d1", mget_d(20'h301), 64'hC0DE_0000_0000_0000);

        s_wr = n_wr;
        run(20'h400, 20'h500, 10, 1'b0, 1'b0, '0, '0, 3, lat);
        check("abort_nwr", n_wr - s_wr, 3);
        check("abort_words", words_done, 3);
        check("abort_flag", aborted, 1);
        check("abort_lat", lat, 16);

        poke(20'h600, 64'hFEED_FACE_CAFE_0600, 8'h66);
        run(20'h600, 20'h601, 3, 1'b0, 1'b0, '0, '0, 0, lat);
        check("ovl_ab_clr", aborted, 0);
        for (int k = 1; k < 4; k++) begin
            check("ovl_data", mget_d(20'h600 + 20'(k)),
                  64'hFEED_FACE_CAFE_0600);
            check("ovl_tag", mget_t(20'h600 + 20'(k)), 8'h66);
        end

        s_rd = n_rd;
`ifdef MEMCOPY_FILL_EN
        run(20'h900, 20'h40, 3, 1'b0, 1'b1, 64'hDEADBEEF_00000001, 8'h07,
            0, lat);
        check("fill_lat", lat, 7);
        check("fill_nrd", n_rd - s_rd, 0);
        for (int k = 0; k < 3; k++) begin
            check("fill_data", mget_d(20'h40 + 20'(k)), 64'hDEADBEEF_00000001);
            check("fill_tag", mget_t(20'h40 + 20'(k)), 8'h07);
        end
`else
        run(20'h900, 20'h40, 3, 1'b0, 1'b1, 64'hDEADBEEF_00000001, 8'h07,
            0, lat);
        check("nofill_lat", lat, 16);
        check("nofill_nrd", n_rd - s_rd, 3);
        check("nofill_data", mget_d(20'h41), 64'hC0DE_0000_0000_0901);
`endif

        @(posedge clk);
        #1;
        cmd_src    = 20'h100;
        cmd_dst    = 20'h800;
        cmd_count  = 20'd2;
        cmd_wforce = 1'b0;
        cmd_fill   = 1'b0;
        cmd_valid  = 1'b1;
        build(20'h100, 20'h800, 1'b0, 1'b0, '0, '0, 2, 1'b0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_wr", o_wr, 1);
        in_reset = 1'b1;
        reset_n  = 1'b0;
        #1;
        check("rst_wr_drop", {o_astb, o_rd, o_wr}, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_words", words_done, 0);
        exp_q.delete();
        last_wd = '0;
        last_ab = 1'b0;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_reset = 1'b0;
        check("rst_lost_wr", mem_d.exists(32'h800), 0);

        run(20'h100, 20'h700, 1, 1'b0, 1'b0, '0, '0, 0, lat);
        check("post_rst_lat", lat, 6);
        check("post_rst_data", mget_d(20'h700), 64'h1234_5678_0000_0100);
        repeat (3) @(posedge clk);
        check("tail_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
